// File: rtl/midi_out_tx.sv
// MIDI OUT transmitter: one channel-voice message per handshake, serialized as
// 8N1 at BAUD with optional running-status suppression of a repeated status byte.
module midi_out_tx #(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned BAUD           = 31250,
   parameter bit          RUNNING_STATUS = 1'b1
) (
   input  logic       clk50M,
   input  logic       rst,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [3:0] ch_message,
   input  logic [3:0] chan,
   input  logic [6:0] data1,
   input  logic [6:0] data2,
   output logic       midi_out,
   output logic       busy,
   output logic       byte_strobe
);

   localparam int unsigned BIT_DIV = CLK_HZ / BAUD;
   localparam int unsigned CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic [7:0]       r_q0;
   logic [7:0]       r_q1;
   logic [1:0]       r_nrem;
   logic [7:0]       r_last;
   logic             r_last_vld;
   logic             r_line;
   logic             w_line_nxt;

   logic       w_xfer;
   logic       w_msg_ok;
   logic       w_two_byte;
   logic       w_skip_status;
   logic       w_cell_end;
   logic [7:0] w_status;

   assign w_status      = {ch_message, chan};
   assign w_xfer        = msg_valid && msg_ready;
   assign w_msg_ok      = ch_message[3] && (ch_message != 4'hF);
   assign w_two_byte    = (ch_message == 4'hC) || (ch_message == 4'hD);
   assign w_skip_status = RUNNING_STATUS && r_last_vld && (r_last == w_status);
   assign w_cell_end    = (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_line_nxt  = r_line;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer && w_msg_ok) begin
               w_state_nxt = ST_START;
               w_line_nxt  = 1'b0;
            end
         end
         ST_START: begin
            if (w_cell_end) begin
               w_state_nxt = ST_DATA;
               w_line_nxt  = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_cell_end) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = ST_STOP;
                  w_line_nxt  = 1'b1;
               end else begin
                  w_line_nxt  = r_shift[1];
               end
            end
         end
         ST_STOP: begin
            if (w_cell_end) begin
               if (r_nrem != 2'd0) begin
                  w_state_nxt = ST_START;
                  w_line_nxt  = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_line_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_line_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_line     <= 1'b1;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_q0       <= '0;
         r_q1       <= '0;
         r_nrem     <= '0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_line  <= w_line_nxt;
         r_cnt   <= (r_state == ST_IDLE || w_cell_end) ? '0 : r_cnt + CNT_W'(1);
         case (r_state)
            ST_IDLE: begin
               // Pending bytes: r_shift is on the line next, r_q0/r_q1 follow in order.
               if (w_xfer && w_msg_ok) begin
                  r_bit <= '0;
                  if (w_skip_status) begin
                     r_shift <= {1'b0, data1};
                     r_q0    <= {1'b0, data2};
                     r_q1    <= '0;
                     r_nrem  <= w_two_byte ? 2'd0 : 2'd1;
                  end else begin
                     r_shift    <= w_status;
                     r_q0       <= {1'b0, data1};
                     r_q1       <= {1'b0, data2};
                     r_nrem     <= w_two_byte ? 2'd1 : 2'd2;
                     r_last     <= w_status;
                     r_last_vld <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_cell_end) begin
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
               end
            end
            ST_STOP: begin
               if (w_cell_end && r_nrem != 2'd0) begin
                  r_shift <= r_q0;
                  r_q0    <= r_q1;
                  r_nrem  <= r_nrem - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign midi_out    = r_line;
   assign busy        = (r_state != ST_IDLE);
   assign msg_ready   = (r_state == ST_IDLE) && !rst;
   assign byte_strobe = (r_state == ST_STOP) && w_cell_end;

endmodule

// File: tb/tb_midi_out_tx.sv
// Bench for midi_out_tx: two instances (running status on/off) at 16 clocks per bit,
// line checked cell by cell against byte lists derived from MIDI message rules.
module tb_midi_out_tx;

   localparam int unsigned CLK_HZ = 500000;
   localparam int unsigned BAUD   = 31250;
   localparam int          BD     = 16;

   logic clk50M = 1'b0;
   always #5 clk50M = ~clk50M;

   logic [1:0]      rst;
   logic [1:0]      valid;
   logic [1:0][3:0] stn;
   logic [1:0][3:0] chn;
   logic [1:0][6:0] d1;
   logic [1:0][6:0] d2;
   logic [1:0]      ready;
   logic [1:0]      line;
   logic [1:0]      busy;
   logic [1:0]      strb;

   midi_out_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1'b1)) u_dut (
      .clk50M(clk50M), .rst(rst[0]), .msg_valid(valid[0]), .msg_ready(ready[0]),
      .ch_message(stn[0]), .chan(chn[0]), .data1(d1[0]), .data2(d2[0]),
      .midi_out(line[0]), .busy(busy[0]), .byte_strobe(strb[0])
   );

   midi_out_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1'b0)) u_dut_nors (
      .clk50M(clk50M), .rst(rst[1]), .msg_valid(valid[1]), .msg_ready(ready[1]),
      .ch_message(stn[1]), .chan(chn[1]), .data1(d1[1]), .data2(d2[1]),
      .midi_out(line[1]), .busy(busy[1]), .byte_strobe(strb[1])
   );

   int total = 0;
   int bad   = 0;
   int last_st[2];
   logic [7:0] eb[3];
   int en;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected bytes for one message; instance 0 suppresses a repeated status.
   task automatic model(input int d, input logic [3:0] s, input logic [3:0] c,
                        input logic [6:0] a, input logic [6:0] b);
      int stb;
      en = 0;
      if (s < 4'd8 || s == 4'hF) return;
      stb = {24'd0, s, c};
      if (!(d == 0 && last_st[0] == stb)) begin
         eb[en] = stb[7:0];
         en++;
         last_st[d] = stb;
      end
      eb[en] = {1'b0, a};
      en++;
      if (!(s == 4'hC || s == 4'hD)) begin
         eb[en] = {1'b0, b};
         en++;
      end
   endtask

   task automatic drive(input int d, input logic [3:0] s, input logic [3:0] c,
                        input logic [6:0] a, input logic [6:0] b);
      valid[d] = 1'b1;
      stn[d]   = s;
      chn[d]   = c;
      d1[d]    = a;
      d2[d]    = b;
   endtask

   // Waits for acceptance; returns at the sample point of cycle 1 after the accept edge.
   task automatic accept(input int d, output bit ok);
      int w = 0;
      while (ready[d] !== 1'b1 && w < 2000) begin
         @(posedge clk50M); #1;
         w++;
      end
      ok = (w < 2000);
      chk("accept_wait", {31'd0, ok}, 32'd1);
      chk("idle_line", {31'd0, line[d]}, 32'd1);
      @(posedge clk50M); #1;
   endtask

   task automatic xfer(input int d, input logic [3:0] s, input logic [3:0] c,
                       input logic [6:0] a, input logic [6:0] b, input bit hold,
                       input logic [3:0] hs, input logic [3:0] hc,
                       input logic [6:0] ha, input logic [6:0] hb);
      bit ok;
      drive(d, s, c, a, b);
      accept(d, ok);
      if (!ok) begin
         valid[d] = 1'b0;
         return;
      end
      model(d, s, c, a, b);
      if (hold) drive(d, hs, hc, ha, hb);
      else valid[d] = 1'b0;
      if (en == 0) begin
         logic l_ok, r_ok;
         int nst;
         l_ok = 1'b1; r_ok = 1'b1; nst = 0;
         for (int i = 0; i < 100; i++) begin
            if (line[d] !== 1'b1) l_ok = 1'b0;
            if (ready[d] !== 1'b1) r_ok = 1'b0;
            if (strb[d] !== 1'b0) nst++;
            @(posedge clk50M); #1;
         end
         chk("inv_line_idle", {31'd0, l_ok}, 32'd1);
         chk("inv_ready", {31'd0, r_ok}, 32'd1);
         chk("inv_strobes", nst, 0);
         return;
      end
      for (int j = 0; j < en * 10; j++) begin
         logic expb, obs_line, lst, bsy_all, rdy_any;
         int pos, nst;
         pos = j % 10;
         if (pos == 0) expb = 1'b0;
         else if (pos == 9) expb = 1'b1;
         else expb = eb[j / 10][pos - 1];
         obs_line = expb; nst = 0; lst = 1'b0; bsy_all = 1'b1; rdy_any = 1'b0;
         for (int i = 0; i < BD; i++) begin
            if (line[d] !== expb) obs_line = line[d];
            if (strb[d] === 1'b1) nst++;
            if (i == BD - 1) lst = strb[d];
            if (busy[d] !== 1'b1) bsy_all = 1'b0;
            if (ready[d] !== 1'b0) rdy_any = 1'b1;
            @(posedge clk50M); #1;
         end
         chk($sformatf("line_b%0d_c%0d", j / 10, pos), {31'd0, obs_line}, {31'd0, expb});
         chk($sformatf("strobe_b%0d_c%0d", j / 10, pos), nst * 2 + int'(lst),
             (pos == 9) ? 3 : 0);
         chk($sformatf("busy_ready_b%0d_c%0d", j / 10, pos), {30'd0, bsy_all, rdy_any}, 32'd2);
      end
      chk("end_ready", {31'd0, ready[d]}, 32'd1);
      chk("end_busy", {31'd0, busy[d]}, 32'd0);
      chk("end_line", {31'd0, line[d]}, 32'd1);
   endtask

   task automatic send(input int d, input logic [3:0] s, input logic [3:0] c,
                       input logic [6:0] a, input logic [6:0] b);
      xfer(d, s, c, a, b, 1'b0, 4'h0, 4'h0, 7'h0, 7'h0);
   endtask

   initial begin
      bit ok;
      rst = 2'b11; valid = 2'b00;
      stn = '0; chn = '0; d1 = '0; d2 = '0;
      last_st[0] = -1; last_st[1] = -1;
      repeat (3) @(posedge clk50M);
      #1;
      chk("rst_line", {31'd0, line[0]}, 32'd1);
      chk("rst_ready", {31'd0, ready[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy[0]}, 32'd0);
      chk("rst_strobe", {31'd0, strb[0]}, 32'd0);
      chk("rst_line_nors", {31'd0, line[1]}, 32'd1);
      rst = 2'b00;
      #1;
      chk("post_rst_ready", {31'd0, ready[0]}, 32'd1);

      // Note on, running status repeat, note off, program change, pitch bend.
      send(0, 4'h9, 4'h0, 7'd60, 7'd100);
      send(0, 4'h9, 4'h0, 7'd62, 7'd90);
      send(0, 4'h8, 4'h0, 7'd60, 7'd0);
      send(0, 4'hC, 4'h5, 7'd7, 7'd99);
      send(0, 4'hE, 4'hF, 7'd0, 7'd64);

      // Held request with different data during a transfer.
      xfer(0, 4'hB, 4'h2, 7'd7, 7'd127, 1'b1, 4'h9, 4'h3, 7'd64, 7'd1);
      send(0, 4'h9, 4'h3, 7'd64, 7'd1);

      // Invalid nibbles leave running status intact.
      send(0, 4'h3, 4'h3, 7'd1, 7'd2);
      send(0, 4'hF, 4'h3, 7'd1, 7'd2);
      send(0, 4'h9, 4'h3, 7'd65, 7'd2);

      // Reset in the middle of a data bit of byte 2.
      drive(0, 4'h9, 4'h0, 7'd60, 7'd100);
      accept(0, ok);
      valid[0] = 1'b0;
      model(0, 4'h9, 4'h0, 7'd60, 7'd100);
      repeat (13 * BD + BD / 2) @(posedge clk50M);
      #1;
      chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
      rst[0] = 1'b1;
      @(posedge clk50M); #1;
      chk("mid_rst_line", {31'd0, line[0]}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
      chk("mid_rst_strobe", {31'd0, strb[0]}, 32'd0);
      rst[0] = 1'b0;
      last_st[0] = -1;
      #1;
      chk("mid_rst_ready", {31'd0, ready[0]}, 32'd1);
      send(0, 4'h9, 4'h0, 7'd60, 7'd100);

      // Randomized messages; few channels so running status hits often.
      for (int k = 0; k < 20; k++) begin
         logic [3:0] s;
         s = (k % 7 == 6) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 14));
         send(0, s, 4'($urandom_range(0, 1)), 7'($urandom), 7'($urandom));
      end

      // Running status disabled: status always resent.
      send(1, 4'h9, 4'h0, 7'd60, 7'd100);
      send(1, 4'h9, 4'h0, 7'd62, 7'd90);
      send(1, 4'hC, 4'h5, 7'd7, 7'd99);
      send(1, 4'hC, 4'h5, 7'd8, 7'd99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
